// File: rtl/mem_stage.sv
// Memory stage of the RV32I pipeline: drives the req/ack data-memory port,
// stalls upstream while an access is pending and registers the writeback slot.
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_write_data,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic        ex_reg_write,
    input  logic [4:0]  ex_rd,
    input  logic [2:0]  ex_funct3,
    output logic        stall,
    output logic [31:0] bp_mem,
    output logic [4:0]  mem_rd,
    output logic        mem_reg_write,
    output logic        mem_is_load,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misalign_err,
    output logic        bus_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [1:0]       ofs;
    logic             is_half;
    logic             is_word;
    logic             is_mem;
    logic             is_load;
    logic             misaligned;
    logic             access;
    logic             abandon;

    function automatic logic [3:0] byte_enables(input logic [1:0] off, input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [31:0] wd, input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    // Lane is selected by shifting the word down; halfwords are aligned here.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] off,
                                                 input logic [2:0] f3);
        logic [31:0] lane;
        lane = word >> {off, 3'b000};
        case (f3)
            3'b000:  return {{24{lane[7]}}, lane[7:0]};
            3'b100:  return {24'b0, lane[7:0]};
            3'b001:  return {{16{lane[15]}}, lane[15:0]};
            3'b101:  return {16'b0, lane[15:0]};
            default: return word;
        endcase
    endfunction

    always_comb begin
        ofs        = ex_alu_result[1:0];
        is_half    = (ex_funct3[1:0] == 2'b01);
        is_word    = ex_funct3[1];
        is_mem     = ex_valid & (ex_mem_read | ex_mem_write);
        is_load    = ex_mem_read & ~ex_mem_write;
        misaligned = is_mem & ((is_half & ofs[0]) | (is_word & (ofs != 2'b00)));
        access     = is_mem & ~misaligned;
        abandon    = (state == WAIT) & ~dmem_ack & (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    end

    // Request and stall are killed combinationally so reset drops them at once.
    assign stall         = rst_n & access & ~dmem_ack & ~abandon;
    assign dmem_req      = rst_n & (access | (state == WAIT));
    assign dmem_we       = dmem_req & ex_mem_write;
    assign dmem_addr     = {ex_alu_result[31:2], 2'b00};
    assign dmem_be       = byte_enables(ofs, ex_funct3);
    assign dmem_wdata    = store_lanes(ex_write_data, ex_funct3);
    assign bp_mem        = ex_alu_result;
    assign mem_rd        = ex_rd;
    assign mem_reg_write = ex_reg_write & ex_valid;
    assign mem_is_load   = ex_mem_read & ex_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            bus_err      <= 1'b0;
            misalign_err <= 1'b0;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
        end else begin
            misalign_err <= misaligned;
            if (abandon) bus_err <= 1'b1;

            case (state)
                IDLE: if (access & ~dmem_ack) begin
                    state    <= WAIT;
                    wait_cnt <= CNT_W'(1);
                end
                WAIT: if (dmem_ack | abandon) begin
                    state    <= IDLE;
                    wait_cnt <= '0;
                end else begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                end
            endcase

            // Stalled cycles emit a bubble; rd/data are left as they were.
            if (stall) begin
                wb_valid     <= 1'b0;
                wb_reg_write <= 1'b0;
            end else begin
                wb_valid     <= ex_valid;
                wb_rd        <= ex_rd;
                wb_reg_write <= ex_valid & ex_reg_write & ~misaligned & ~abandon;
                if (is_load & abandon)
                    wb_data <= '0;
                else if (is_load & access & dmem_ack)
                    wb_data <= load_extract(dmem_rdata, ofs, ex_funct3);
                else
                    wb_data <= ex_alu_result;
            end
        end
    end

endmodule
